y86_alu: RTL and testbench



---
 rtl/y86_pkg.sv | 17 +
 rtl/y86_cc_reg.sv | 25 ++
 rtl/y86_alu.sv | 68 ++++++
 tb/tb_y86_alu.sv | 105 ++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: ALU function codes, condition-code bit layout, word type.
package y86_pkg;

  typedef logic [31:0] word_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // Bit positions inside the packed 3-bit condition-code vector.
  localparam int CC_OF = 0;
  localparam int CC_ZF = 1;
  localparam int CC_SF = 2;
  localparam int CC_W  = 3;

endpackage

// File: rtl/y86_cc_reg.sv
// Three-bit condition-code register with synchronous reset and load enable.
module y86_cc_reg
  import y86_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [CC_W-1:0] cc_next,
  output logic [CC_W-1:0] cc
);

  logic [CC_W-1:0] cc_reg;

  // Reset wins over load so a flush cannot leave stale flags behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_reg <= '0;
    end else if (load) begin
      cc_reg <= cc_next;
    end
  end

  assign cc = cc_reg;

endmodule

// File: rtl/y86_alu.sv
// Y86 execute-stage ALU: combinational valE plus the registered SF/ZF/OF flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  op,
  input  logic        set_cc,
  output logic [31:0] result,
  output logic        SF,
  output logic        ZF,
  output logic        OF
);

  logic            is_sub;
  logic            is_arith;
  logic            op_legal;
  word_t           op2_eff;
  word_t           sum;
  word_t           result_next;
  logic            of_next;
  logic [CC_W-1:0] cc_next;
  logic [CC_W-1:0] cc;

  assign is_sub   = (op == ALU_SUB);
  assign is_arith = (op == ALU_ADD) || (op == ALU_SUB);
  assign op_legal = (op[3:2] == 2'b00);

  // One adder serves both ADD and SUB: subtract is op1 + ~op2 + 1.
  assign op2_eff = op2 ^ {32{is_sub}};
  assign sum     = op1 + op2_eff + {31'd0, is_sub};

  always_comb begin
    result_next = '0;
    unique case (op)
      ALU_ADD, ALU_SUB: result_next = sum;
      ALU_AND:          result_next = op1 & op2;
      ALU_XOR:          result_next = op1 ^ op2;
      default:          result_next = '0;
    endcase
  end

  // Against the effective addend, ADD and SUB share one overflow rule.
  assign of_next = is_arith && (op1[31] == op2_eff[31]) && (sum[31] != op1[31]);

  always_comb begin
    cc_next        = '0;
    cc_next[CC_SF] = result_next[31];
    cc_next[CC_ZF] = (result_next == '0);
    cc_next[CC_OF] = of_next;
  end

  y86_cc_reg u_cc_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (set_cc && op_legal),
    .cc_next (cc_next),
    .cc      (cc)
  );

  assign result = result_next;
  assign SF     = cc[CC_SF];
  assign ZF     = cc[CC_ZF];
  assign OF     = cc[CC_OF];

endmodule

// File: tb/tb_y86_alu.sv
// Directed-vector bench for y86_alu: checks combinational result and registered flags.
module tb_y86_alu;

  logic        clock;
  logic        reset;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  op;
  logic        set_cc;
  logic [31:0] result;
  logic        SF;
  logic        ZF;
  logic        OF;

  int tests_run;
  int tests_failed;
  logic [2:0] flags_prev;
  logic       flags_known;

  y86_alu dut (
    .clock  (clock),
    .reset  (reset),
    .op1    (op1),
    .op2    (op2),
    .op     (op),
    .set_cc (set_cc),
    .result (result),
    .SF     (SF),
    .ZF     (ZF),
    .OF     (OF)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: drive, check result and pre-edge flags, clock, check flags {SF,ZF,OF}.
  task automatic step(input string tag, input logic rst, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] f, input logic sc,
                      input logic [31:0] exp_res, input logic [2:0] exp_flags);
    reset  = rst;
    op1    = a;
    op2    = b;
    op     = f;
    set_cc = sc;
    #1;
    check({tag, ".result"}, result, exp_res);
    if (flags_known)
      check({tag, ".flags_before_edge"}, {29'd0, SF, ZF, OF}, {29'd0, flags_prev});
    @(posedge clock);
    #1;
    check({tag, ".flags"}, {29'd0, SF, ZF, OF}, {29'd0, exp_flags});
    $display("[TB] %s: op=%0d op1=0x%08h op2=0x%08h set_cc=%0b reset=%0b -> result=0x%08h SF=%0b ZF=%0b OF=%0b",
             tag, f, a, b, sc, rst, result, SF, ZF, OF);
    flags_prev  = exp_flags;
    flags_known = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    flags_prev   = 3'b000;
    flags_known  = 1'b0;
    reset  = 1'b0;
    op1    = '0;
    op2    = '0;
    op     = '0;
    set_cc = 1'b0;
    @(posedge clock);
    #1;

    //    tag             rst  op1            op2            op     sc    result         {SF,ZF,OF}
    step("reset",         1'b1, 32'h0000_0000, 32'h0000_0000, 4'd0,  1'b1, 32'h0000_0000, 3'b000);
    step("add_ovf",       1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  1'b1, 32'h8000_0000, 3'b101);
    step("add_carry",     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  1'b1, 32'h0000_0000, 3'b010);
    step("sub_zero",      1'b0, 32'h0000_0005, 32'h0000_0005, 4'd1,  1'b1, 32'h0000_0000, 3'b010);
    step("sub_neg",       1'b0, 32'h0000_0003, 32'h0000_0005, 4'd1,  1'b1, 32'hFFFF_FFFE, 3'b100);
    step("sub_ovf",       1'b0, 32'h8000_0000, 32'h0000_0001, 4'd1,  1'b1, 32'h7FFF_FFFF, 3'b001);
    step("sub_neg_ok",    1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'd1,  1'b1, 32'h8000_0000, 3'b100);
    step("and_zero",      1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd2,  1'b1, 32'h0000_0000, 3'b010);
    step("and_mix",       1'b0, 32'hFF00_FF00, 32'hF0F0_F0F0, 4'd2,  1'b1, 32'hF000_F000, 3'b100);
    step("xor_ones",      1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 4'd3,  1'b1, 32'hFFFF_FFFF, 3'b100);
    step("xor_pos",       1'b0, 32'h1234_5678, 32'h1234_0000, 4'd3,  1'b1, 32'h0000_5678, 3'b000);
    step("add_prep",      1'b0, 32'h8000_0000, 32'h8000_0000, 4'd0,  1'b1, 32'h0000_0000, 3'b011);
    step("hold",          1'b0, 32'h0000_0000, 32'h0000_0000, 4'd1,  1'b0, 32'h0000_0000, 3'b011);
    step("sub_prep",      1'b0, 32'h0000_0003, 32'h0000_0005, 4'd1,  1'b1, 32'hFFFF_FFFE, 3'b100);
    step("illegal7",      1'b0, 32'h0000_0003, 32'h0000_0005, 4'd7,  1'b1, 32'h0000_0000, 3'b100);
    step("illegal4",      1'b0, 32'h0000_0000, 32'h0000_0000, 4'd4,  1'b1, 32'h0000_0000, 3'b100);
    step("illegal15",     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd15, 1'b1, 32'h0000_0000, 3'b100);
    step("reset_track",   1'b1, 32'h0000_0002, 32'h0000_0003, 4'd0,  1'b1, 32'h0000_0005, 3'b000);
    step("set_again",     1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  1'b1, 32'h8000_0000, 3'b101);
    step("reset_prio",    1'b1, 32'h0000_0000, 32'h0000_0000, 4'd0,  1'b1, 32'h0000_0000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
